klingon_bcd_scan_counter: RTL and testbench
===========================================

Name: klingon_bcd_scan_counter

Overview:
- 4-digit BCD up/down counter with prescaled count tick, plus a time-multiplexed digit scanner.
- Sits directly upstream of the team's Klingon 4-bit-to-7-segment digit decoder.
- Each scan slot presents one 4-bit digit (0-9) on `digit` and a one-hot digit-select on `sel`.
- The decoder combinationally converts `digit` to segments.

Parameters:
- PRESCALE, 50000000, clk cycles per count tick (>=2)
- SCAN_DIV, 50000, clk cycles per scan slot (>=2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  count enable; gates the prescaler
- up  input  1  1 = count up, 0 = count down; sampled on tick
- load  input  1  synchronous load strobe
- load_val  input  16  four BCD digits, [15:12] most significant
- count  output  16  current BCD value, registered
- digit  output  4  BCD digit for the decoder, registered
- sel  output  4  one-hot digit select, active high, registered; bit i = digit i
- carry  output  1  one-cycle pulse on wrap 9999->0000 (up) or 0000->9999 (down)

Behaviour:
- Clock and reset:
  - One clock domain (clk).
  - Reset is asynchronous, active-low (rst_n).
  - While rst_n=0: count=0, prescaler=0, scan divider=0, scan index=0, digit=0, sel=4'b0001, carry=0.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1 and holds while en=0.
  - tick is asserted when prescaler==PRESCALE-1 and en=1; the prescaler then returns to 0.
  - First tick after reset occurs on cycle PRESCALE.
- Counter update, per cycle in priority order:
  1. load=1: each nibble of load_val is stored; a nibble >9 is stored as 0. Prescaler clears to 0, carry=0, and any coincident tick is discarded.
  2. tick=1, up=1: BCD increment. Digit 9 becomes 0 and carries into the next digit. 9999 becomes 0000 with carry=1 for that cycle.
  3. tick=1, up=0: BCD decrement. Digit 0 becomes 9 and borrows. 0000 becomes 9999 with carry=1.
  4. Otherwise: count holds, carry=0.
- count always holds valid BCD (each nibble 0-9).
- Scanner:
  - Runs independently of en and load.
  - The scan divider counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps and the 2-bit index advances 0->1->2->3->0.
  - digit and sel are registered from the same index on the same edge, so they never disagree.
  - sel = 1<<index; digit = count nibble [4*index+3 : 4*index], taken from count's current registered value.
  - A count change shows on digit no later than the next scan advance; there is no tearing within a slot.
- Timing:
  - Latency: a load or tick is visible on count 1 cycle after the qualifying edge.
  - carry is coincident with the wrapped count value.
- Reset mid-operation: immediate asynchronous return to the reset values above. The scan restarts at index 0, and the first advance comes SCAN_DIV cycles after rst_n deasserts.

Decomposition:
- Shared package: BCD digit width (4), digit count (4), sel reset value (4'b0001), BCD max digit (9).
- Natural sub-module: `bcd_digit_updown`, one BCD digit with carry/borrow in and out, instantiated four times in a ripple chain.
- Prescaler, scanner and top-level control stay in this module.

Test Plan (PRESCALE=4, SCAN_DIV=2):
- Reset, then en=1, up=1 for 40 cycles -> count=0x0010 after 10 ticks; a tick lands every 4th cycle; carry stays 0.
- load=1, load_val=0x9998, then en=1, up=1 -> 0x9999, then 0x0000 with carry=1 for exactly one cycle, then 0x0001.
- load_val=0x0000, up=0, en=1 -> 0x9999 with a carry pulse, then 0x9998.
- load_val=0xA5FC -> count=0x0500.
- load asserted in the same cycle as a tick -> count equals load_val and no increment occurs; the next tick arrives 4 cycles later.
- count=0x1234 held with en=0 -> sel cycles 0001, 0010, 0100, 1000, advancing every 2 cycles, with digit 4, 3, 2, 1 respectively.
- rst_n pulsed low asynchronously mid-scan -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/klingon_bcd_scan_counter_pkg.sv
// Shared constants and helpers for the BCD scan counter and its digit cells.
package klingon_bcd_scan_counter_pkg;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [NUM_DIGITS-1:0] SEL_RST = 4'b0001;
  localparam logic [BCD_W-1:0]      BCD_MAX = 4'd9;

  // Loaded nibbles outside 0-9 collapse to 0 so count stays valid BCD.
  function automatic logic [BCD_W-1:0] bcd_sanitize(input logic [BCD_W-1:0] n);
    return (n > BCD_MAX) ? '0 : n;
  endfunction

endpackage

// File: rtl/klingon_bcd_scan_counter_digit.sv
// One BCD digit step cell: +/-1 when cin is set, rippling carry/borrow to cout.
module bcd_digit_updown
  import klingon_bcd_scan_counter_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  input  logic             up,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (d >= BCD_MAX) begin
          q    = '0;
          cout = 1'b1;
        end else begin
          q = d + BCD_W'(1);
        end
      end else begin
        if (d == '0) begin
          q    = BCD_MAX;
          cout = 1'b1;
        end else begin
          q = d - BCD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/klingon_bcd_scan_counter.sv
// 4-digit BCD up/down counter with prescaled tick and a one-hot digit scanner
// feeding the 7-segment decoder.
module klingon_bcd_scan_counter
  import klingon_bcd_scan_counter_pkg::*;
#(
  parameter int PRESCALE = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [15:0]           load_val,
  output logic [15:0]           count,
  output logic [BCD_W-1:0]      digit,
  output logic [NUM_DIGITS-1:0] sel,
  output logic                  carry
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam int SD_W = $clog2(SCAN_DIV);

  logic [PS_W-1:0] ps;
  logic            tick;

  logic [NUM_DIGITS-1:0][BCD_W-1:0] cnt_q, cnt_nxt, load_dig;
  logic [NUM_DIGITS:0]              chain;

  logic [SD_W-1:0]  sdiv;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             scan_wrap;

  assign tick  = en && (ps == PS_W'(PRESCALE - 1));
  assign count = cnt_q;

  // ---------------- prescaler ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ps <= '0;
    else if (load)    ps <= '0;
    else if (en)      ps <= tick ? '0 : ps + PS_W'(1);
  end

  // ---------------- digit ripple chain ----------------
  // The tick enters the LSD; a wrap out of the MSD is the carry pulse.
  assign chain[0] = tick;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit_updown u_dig (
      .d    (cnt_q[g]),
      .up   (up),
      .cin  (chain[g]),
      .q    (cnt_nxt[g]),
      .cout (chain[g+1])
    );
    assign load_dig[g] = bcd_sanitize(load_val[g*BCD_W +: BCD_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      carry <= 1'b0;
    end else if (load) begin
      cnt_q <= load_dig;
      carry <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      carry <= chain[NUM_DIGITS];
    end
  end

  // ---------------- scanner ----------------
  // digit/sel only change on a slot advance, so a slot never shows a torn value.
  assign scan_wrap = (sdiv == SD_W'(SCAN_DIV - 1));
  assign idx_nxt   = idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdiv  <= '0;
      idx   <= '0;
      sel   <= SEL_RST;
      digit <= '0;
    end else if (scan_wrap) begin
      sdiv  <= '0;
      idx   <= idx_nxt;
      sel   <= SEL_RST << idx_nxt;
      digit <= cnt_q[idx_nxt];
    end else begin
      sdiv  <= sdiv + SD_W'(1);
    end
  end

endmodule

// File: tb/tb_klingon_bcd_scan_counter.sv
// Randomized + directed bench for klingon_bcd_scan_counter against a decimal reference model.
module tb_klingon_bcd_scan_counter;

  localparam int PRESCALE = 4;
  localparam int SCAN_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, up, load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic [3:0]  digit;
  logic [3:0]  sel;
  logic        carry;

  int errors = 0;
  int checks = 0;

  // reference model state: count kept as a plain decimal integer
  int m_cnt, m_ps, m_sdiv, m_idx, m_digit, m_sel, m_carry;

  klingon_bcd_scan_counter #(.PRESCALE(PRESCALE), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .digit(digit), .sel(sel), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    int r = 0, p = 1;
    for (int i = 0; i < 4; i++) begin
      r |= ((v / p) % 10) << (4 * i);
      p *= 10;
    end
    return r;
  endfunction

  function automatic int from_load(input int lv);
    int r = 0, p = 1, n;
    for (int i = 0; i < 4; i++) begin
      n = (lv >> (4 * i)) & 15;
      if (n > 9) n = 0;
      r += n * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic int dec_digit(input int v, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p *= 10;
    return (v / p) % 10;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_ps = 0; m_sdiv = 0; m_idx = 0; m_digit = 0; m_sel = 1; m_carry = 0;
  endtask

  task automatic model_clock(input bit e, input bit u, input bit ld, input int lv);
    bit t;
    int old = m_cnt;
    t = e && (m_ps == PRESCALE - 1);
    if (m_sdiv == SCAN_DIV - 1) begin
      m_sdiv  = 0;
      m_idx   = (m_idx + 1) % 4;
      m_sel   = 1 << m_idx;
      m_digit = dec_digit(old, m_idx);
    end else begin
      m_sdiv++;
    end
    if (ld) begin
      m_cnt = from_load(lv); m_ps = 0; m_carry = 0;
    end else begin
      m_carry = 0;
      if (t && u) begin
        m_carry = (m_cnt == 9999); m_cnt = (m_cnt + 1) % 10000;
      end else if (t) begin
        m_carry = (m_cnt == 0); m_cnt = (m_cnt + 9999) % 10000;
      end
      if (e) m_ps = t ? 0 : m_ps + 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, count, to_bcd(m_cnt));
    chk({tag, ".carry"}, carry, m_carry);
    chk({tag, ".sel"},   sel,   m_sel);
    chk({tag, ".digit"}, digit, m_digit);
  endtask

  // called at a negedge; applies inputs for one clock, checks at the next negedge
  task automatic step(input string tag, input bit e, input bit u, input bit ld, input int lv);
    en = e; up = u; load = ld; load_val = lv[15:0];
    @(posedge clk);
    model_clock(e, u, ld, lv);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 0; up = 0; load = 0; load_val = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) step("up40", 1, 1, 0, 0);
    chk("up40.final", count, 16'h0010);

    step("ld9998", 0, 1, 1, 16'h9998);
    for (int i = 0; i < 14; i++) step("wrapup", 1, 1, 0, 0);

    step("ld0000", 0, 0, 1, 16'h0000);
    for (int i = 0; i < 10; i++) step("wrapdn", 1, 0, 0, 0);

    step("ldA5FC", 0, 0, 1, 16'hA5FC);
    chk("ldA5FC.val", count, 16'h0500);

    step("ldtick0", 1, 1, 1, 0);
    for (int i = 0; i < 8 && m_ps != PRESCALE - 1; i++) step("ldtick.pre", 1, 1, 0, 0);
    step("ldtick", 1, 1, 1, 16'h4321);
    chk("ldtick.noinc", count, 16'h4321);
    for (int i = 0; i < 3; i++) step("ldtick.hold", 1, 1, 0, 0);
    chk("ldtick.hold3", count, 16'h4321);
    step("ldtick.next", 1, 1, 0, 0);
    chk("ldtick.tick4", count, 16'h4322);

    step("ld1234", 0, 0, 1, 16'h1234);
    for (int i = 0; i < 12; i++) step("scan", 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      bit ld = ($urandom_range(15) == 0);
      int lv = (ld && $urandom_range(3) == 0) ? 16'h9999 * $urandom_range(1)
                                               : int'($urandom_range(16'hFFFF));
      step("rand", $urandom_range(3) != 0, $urandom_range(1), ld, lv);
    end

    // asynchronous reset between edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset.count", count, 0);
    chk("areset.digit", digit, 0);
    chk("areset.sel",   sel,   1);
    chk("areset.carry", carry, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step("postrst", 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
